// File: rtl/regbank_mp.sv
// Parametrised multi-port register bank with write-through bypass,
// optional hardwired zero register and a per-register pending scoreboard.
//
// Ports:
//   CLK, aRST              clock (rising edge), async active-high reset
//   ENA_WRITE, WRITE_REG,
//   WRITE_DATA             write-back port (also clears pending)
//   READREG, read_data     NREAD packed read ports, combinational
//   read_pend              per-port hazard flag
//   SET_PEND, PEND_REG     mark a register as awaiting write-back
//   FLUSH                  clear every pending bit
//   pend_count             number of pending registers (registered)
module regbank_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                   CLK,
  input  logic                   aRST,
  input  logic                   ENA_WRITE,
  input  logic [AW-1:0]          WRITE_REG,
  input  logic [WIDTH-1:0]       WRITE_DATA,
  input  logic [NREAD*AW-1:0]    READREG,
  output logic [NREAD*WIDTH-1:0] read_data,
  output logic [NREAD-1:0]       read_pend,
  input  logic                   SET_PEND,
  input  logic [AW-1:0]          PEND_REG,
  input  logic                   FLUSH,
  output logic [CW-1:0]          pend_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [CW-1:0]    inc;
  logic [CW-1:0]    dec;
  logic             wr_zero;
  logic             wr_ok;

  assign wr_zero = (ZERO_REG != 0) && (WRITE_REG == '0);
  assign wr_ok   = ENA_WRITE && !wr_zero;

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[WRITE_REG] = WRITE_DATA;
    end
  end

  // Set beats a simultaneous clear: the newly issued producer
  // supersedes the value currently being written back.
  always_comb begin
    pend_d = pend_q;
    inc    = '0;
    dec    = '0;
    for (int r = 0; r < DEPTH; r++) begin
      logic set_r;
      logic clr_r;
      set_r = SET_PEND && (PEND_REG == AW'(r))
              && !((ZERO_REG != 0) && (r == 0));
      clr_r = ENA_WRITE && (WRITE_REG == AW'(r));
      if (FLUSH) begin
        pend_d[r] = 1'b0;
      end else if (set_r) begin
        pend_d[r] = 1'b1;
      end else if (clr_r) begin
        pend_d[r] = 1'b0;
      end
      if (!pend_q[r] && pend_d[r]) begin
        inc = inc + CW'(1);
      end
      if (pend_q[r] && !pend_d[r]) begin
        dec = dec + CW'(1);
      end
    end
    cnt_d = cnt_q + inc - dec;
  end

  always_ff @(posedge CLK or posedge aRST) begin
    if (aRST) begin
      mem_q  <= '{default: '0};
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_count = cnt_q;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          zr;
    logic          hit;
    assign ra  = READREG[k*AW +: AW];
    assign zr  = (ZERO_REG != 0) && (ra == '0);
    // Bypass is suppressed during reset so outputs read zero at once.
    assign hit = (BYPASS != 0) && ENA_WRITE && !aRST
                 && (WRITE_REG == ra) && !zr;
    assign read_data[k*WIDTH +: WIDTH] =
      zr  ? '0 :
      hit ? WRITE_DATA : mem_q[ra];
    assign read_pend[k] = pend_q[ra] && !hit;
  end

endmodule

// File: tb/tb_regbank_mp.sv
// Directed table-driven bench for regbank_mp (32x32, 2 read ports,
// bypass on, zero register on).
module tb_regbank_mp;

  logic        CLK = 1'b0;
  logic        aRST = 1'b1;
  logic        ENA_WRITE = 1'b0;
  logic [4:0]  WRITE_REG = '0;
  logic [31:0] WRITE_DATA = '0;
  logic [9:0]  READREG = '0;
  logic [63:0] read_data;
  logic [1:0]  read_pend;
  logic        SET_PEND = 1'b0;
  logic [4:0]  PEND_REG = '0;
  logic        FLUSH = 1'b0;
  logic [5:0]  pend_count;

  regbank_mp #(
    .WIDTH(32), .DEPTH(32), .NREAD(2), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .CLK(CLK), .aRST(aRST), .ENA_WRITE(ENA_WRITE),
    .WRITE_REG(WRITE_REG), .WRITE_DATA(WRITE_DATA),
    .READREG(READREG), .read_data(read_data), .read_pend(read_pend),
    .SET_PEND(SET_PEND), .PEND_REG(PEND_REG), .FLUSH(FLUSH),
    .pend_count(pend_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        ena;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic        set;
    logic [4:0]  preg;
    logic        flush;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [1:0]  e_p;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(
    string name, logic ena, logic [4:0] wreg, logic [31:0] wdata,
    logic [4:0] r0, logic [4:0] r1, logic set, logic [4:0] preg,
    logic flush, logic [31:0] e_d0, logic [31:0] e_d1,
    logic [1:0] e_p, logic [5:0] e_cnt);
    vec_t v;
    v.name = name; v.ena = ena; v.wreg = wreg; v.wdata = wdata;
    v.r0 = r0; v.r1 = r1; v.set = set; v.preg = preg;
    v.flush = flush; v.e_d0 = e_d0; v.e_d1 = e_d1;
    v.e_p = e_p; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] d0, logic [31:0] d1,
                     logic [1:0] p, logic [5:0] c);
    n_vec++;
    if (read_data !== {d1, d0} || read_pend !== p
        || pend_count !== c) begin
      n_bad++;
      $display("FAIL %s: got data=%h pend=%b cnt=%0d, want data=%h pend=%b cnt=%0d",
               name, read_data, read_pend, pend_count, {d1, d0}, p, c);
    end
  endtask

  task automatic drive(vec_t v);
    ENA_WRITE  = v.ena;
    WRITE_REG  = v.wreg;
    WRITE_DATA = v.wdata;
    READREG    = {v.r1, v.r0};
    SET_PEND   = v.set;
    PEND_REG   = v.preg;
    FLUSH      = v.flush;
  endtask

  function automatic logic [31:0] pat(int i);
    return (i == 0) ? 32'h0 : 32'hA500_0000 + 32'(i);
  endfunction

  initial begin
    // Write sweep: port0 reads the register being written (bypass).
    for (int i = 0; i < 32; i++)
      add("sweep_wr", 1, 5'(i), 32'hA500_0000 + 32'(i), 5'(i), 0,
          0, 0, 0, pat(i), 0, 2'b00, 0);
    for (int i = 0; i < 32; i++)
      add("sweep_rd", 0, 0, 0, 5'(i), 5'((i + 1) % 32),
          0, 0, 0, pat(i), pat((i + 1) % 32), 2'b00, 0);
    // Bypass
    add("byp_w11", 1, 3, 32'h11, 3, 4, 0, 0, 0, 32'h11, pat(4), 2'b00, 0);
    add("byp_w22", 1, 3, 32'h22, 3, 3, 0, 0, 0, 32'h22, 32'h22, 2'b00, 0);
    add("byp_next", 0, 0, 0, 3, 3, 0, 0, 0, 32'h22, 32'h22, 2'b00, 0);
    // Scoreboard basic on r7
    add("sb_set7", 0, 0, 0, 7, 7, 1, 7, 0, pat(7), pat(7), 2'b00, 0);
    add("sb_pend7", 0, 0, 0, 7, 7, 0, 0, 0, pat(7), pat(7), 2'b11, 1);
    add("sb_wr7", 1, 7, 32'h77, 7, 0, 0, 0, 0, 32'h77, 0, 2'b00, 1);
    add("sb_clr7", 0, 0, 0, 7, 7, 0, 0, 0, 32'h77, 32'h77, 2'b00, 0);
    // Set and clear of r9 in one cycle: set wins
    add("sim_9", 1, 9, 32'h99, 9, 9, 1, 9, 0, 32'h99, 32'h99, 2'b00, 0);
    add("sim_9chk", 0, 0, 0, 9, 9, 0, 0, 0, 32'h99, 32'h99, 2'b11, 1);
    add("set_r0", 0, 0, 0, 0, 9, 1, 0, 0, 0, 32'h99, 2'b10, 1);
    add("set_r6", 0, 0, 0, 6, 0, 1, 6, 0, pat(6), 0, 2'b00, 1);
    add("set4_wr6", 1, 6, 32'h66, 6, 4, 1, 4, 0, 32'h66, pat(4), 2'b00, 2);
    add("set4_chk", 0, 0, 0, 4, 6, 0, 0, 0, pat(4), 32'h66, 2'b01, 2);
    // Flush
    add("fl_pre", 0, 0, 0, 9, 4, 1, 0, 1, 32'h99, pat(4), 2'b11, 2);
    add("fl_set1", 0, 0, 0, 1, 9, 1, 1, 0, pat(1), 32'h99, 2'b00, 0);
    add("fl_set2", 0, 0, 0, 1, 2, 1, 2, 0, pat(1), pat(2), 2'b01, 1);
    add("fl_set3", 0, 0, 0, 2, 3, 1, 3, 0, pat(2), 32'h22, 2'b01, 2);
    add("fl_go", 0, 0, 0, 3, 8, 1, 8, 1, 32'h22, pat(8), 2'b01, 3);
    add("fl_chk", 0, 0, 0, 3, 8, 0, 0, 0, 32'h22, pat(8), 2'b00, 0);
    add("fl_chk2", 0, 0, 0, 1, 2, 0, 0, 0, pat(1), pat(2), 2'b00, 0);
    // Clear of a non-pending register does not underflow
    add("clr_np", 1, 5, 32'h55, 5, 5, 0, 0, 0, 32'h55, 32'h55, 2'b00, 0);
    add("clr_np2", 0, 0, 0, 5, 1, 0, 0, 0, 32'h55, pat(1), 2'b00, 0);
    // Writes to r0 are dropped, no bypass
    add("wr_r0", 1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    add("wr_r0chk", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);

    // Reset sequence: write+pend r5, then async reset mid-cycle.
    @(negedge CLK);
    aRST = 1'b0;
    ENA_WRITE = 1; WRITE_REG = 5; WRITE_DATA = 32'hDEAD_BEEF;
    SET_PEND = 1; PEND_REG = 5;
    @(negedge CLK);
    ENA_WRITE = 0; SET_PEND = 0; READREG = {5'd5, 5'd5};
    #1 chk("pre_reset", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11, 1);
    #2;
    ENA_WRITE = 1; WRITE_REG = 5; WRITE_DATA = 32'hCAFE_F00D;
    aRST = 1'b1;
    #1 chk("async_reset", 0, 0, 2'b00, 0);
    @(negedge CLK);
    aRST = 1'b0;
    ENA_WRITE = 1; WRITE_REG = 10; WRITE_DATA = 32'h1234;
    READREG = {5'd10, 5'd5};
    #1 chk("post_reset", 0, 32'h1234, 2'b00, 0);
    @(negedge CLK);
    ENA_WRITE = 0; READREG = {5'd5, 5'd10};
    #1 chk("first_write", 32'h1234, 0, 2'b00, 0);

    foreach (tbl[i]) begin
      @(negedge CLK);
      drive(tbl[i]);
      #1 chk(tbl[i].name, tbl[i].e_d0, tbl[i].e_d1,
             tbl[i].e_p, tbl[i].e_cnt);
    end
    @(negedge CLK);
    ENA_WRITE = 0; SET_PEND = 0; FLUSH = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regbank_mp.md
Name: regbank_mp

Overview:
- Parametrised successor to the processor's 32x32 two-read/one-write register bank.
- Adds configurable width, depth and read-port count, optional write-through bypass, and an optionally hardwired zero register.
- Adds a per-register pending scoreboard (set on issue, cleared on write-back) so the pipeline control can stall on hazards from multi-cycle producers such as loads.
- Sits between decode (read/issue) and write-back in the datapath.

Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers (power of two, >=2); AW = $clog2(DEPTH) is derived, not overridable
- NREAD, 2, number of independent read ports (1..4)
- BYPASS, 1, 1 = a read of the register being written this cycle returns WRITE_DATA; 0 = returns the stored value
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never pending

Ports:
- CLK  in  1  clock, rising-edge active
- aRST  in  1  reset, asynchronous, active-high
- ENA_WRITE  in  1  write enable, sampled at rising CLK
- WRITE_REG  in  AW  write address
- WRITE_DATA  in  WIDTH  write data
- READREG  in  NREAD*AW  read addresses; port k occupies bits [k*AW +: AW]
- read_data  out  NREAD*WIDTH  read data; port k occupies bits [k*WIDTH +: WIDTH]; combinational
- read_pend  out  NREAD  bit k = 1 when port k's register is pending and not satisfied by a bypassed write this cycle
- SET_PEND  in  1  mark PEND_REG as awaiting a write-back
- PEND_REG  in  AW  register to mark
- FLUSH  in  1  synchronously clear all pending bits
- pend_count  out  $clog2(DEPTH+1)  number of currently pending registers

Behaviour:
- One clock, CLK. Reset aRST is asynchronous and active-high.
- Reset (aRST=1), effective immediately and independent of CLK:
  - all registers = 0; all pending bits = 0; pend_count = 0
  - read_data is therefore all zeros and read_pend is all zeros
  - aRST asserted mid-write discards that write
  - release is synchronous to the next CLK edge; the first write is accepted on the first rising edge with aRST=0
- Write:
  - ENA_WRITE=1 at rising CLK stores WRITE_DATA into mem[WRITE_REG]; visible from the next cycle; 1-cycle latency
  - with ZERO_REG=1, a write to address 0 is dropped
- Read:
  - purely combinational from READREG; all ports are independent and may address the same register
  - address 0 with ZERO_REG=1 returns 0
- Bypass (BYPASS=1): if ENA_WRITE=1 and WRITE_REG==READREG[k] (and not the zero register), read_data[k] = WRITE_DATA and read_pend[k] = 0 in the same cycle.
- Scoreboard, evaluated per register r at each rising CLK:
  - set = SET_PEND && PEND_REG==r
  - clr = ENA_WRITE && WRITE_REG==r
  - FLUSH=1 → pend[r] <= 0, overriding everything
  - else set → pend[r] <= 1; set wins over a simultaneous clr, because the new producer supersedes the value being written back
  - else clr → pend[r] <= 0
  - else pend[r] holds
  - SET_PEND on an already-pending register: stays 1, no count change
  - with ZERO_REG=1, register 0 is never set
- read_pend[k] = pend[READREG[k]], masked by the same-cycle bypass when BYPASS=1; with BYPASS=0 it is unmasked.
- pend_count:
  - registered; updated every cycle as previous count + sets that went 0→1 − bits that went 1→0
  - equivalent to the popcount of the pend vector after the edge; a simultaneous set and clear of different registers leaves it unchanged
  - never exceeds DEPTH (DEPTH−1 when ZERO_REG=1) and never underflows; a clear of a non-pending register does not decrement
- Address range: every AW-bit value is a valid register; there is no out-of-range case.

Test Plan:
- Reset: aRST=1 mid-cycle after writing 0xDEADBEEF to r5 → read_data of r5 = 0, read_pend = 0 and pend_count = 0 immediately, without waiting for CLK.
- Full write/read sweep: write r_i = 0xA5000000+i for i = 0..31, then read all pairs (i, i+1 mod 32) → r0 reads 0, every other register reads its pattern on both ports.
- Bypass: r3 = 0x11; same cycle ENA_WRITE with r3 ← 0x22 and READREG0 = 3 → read_data0 = 0x22 (BYPASS=1) or 0x11 (BYPASS=0); next cycle 0x22 in both builds.
- Scoreboard basic: SET_PEND r7 → next cycle read_pend = 1 on any port addressing r7, pend_count = 1; write r7 → next cycle read_pend = 0, pend_count = 0.
- Simultaneous events:
  - SET_PEND r9 with a write to r9 in the same cycle → r9 stays pending, count = 1
  - SET_PEND r0 → count stays 0
  - SET_PEND r4 with a write to r6 (r6 pending) → count unchanged
- FLUSH: set r1, r2, r3 pending (count = 3); FLUSH together with SET_PEND r8 → next cycle all pending bits clear and count = 0.
